// File: rtl/mon_fifo_rdctl.sv
// Read-side controller for the monitor data FIFO: owns the read pointer, requests
// RAM reads, absorbs the one-cycle read latency and hands entries out on valid/ready.
module mon_fifo_rdctl #(
    parameter int AW = 11,
    parameter int DW = 18
) (
    input  logic          clk,
    input  logic          rst_x,
    input  logic          en,
    input  logic          flush,
    input  logic [AW-1:0] waddr,
    output logic          rdreq,
    input  logic          rdack,
    output logic [AW-1:0] raddr,
    input  logic [DW-1:0] rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] level,
    output logic          empty
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic          inflight_q, inflight_d;
    logic [1:0]    count_q, count_d;
    logic [DW-1:0] buf0_q, buf0_d;
    logic [DW-1:0] buf1_q, buf1_d;

    logic          pop;
    logic          push;
    logic          grant;
    logic          clearing;
    logic [1:0]    occupied;
    logic [1:0]    slots_used;
    logic          has_room;

    assign empty     = (raddr_q == waddr);
    assign level     = waddr - raddr_q;
    assign raddr     = raddr_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = buf0_q;

    assign pop      = out_valid & out_ready;
    assign push     = inflight_q;
    assign clearing = flush | (state_q == FLUSH);

    // A slot freed by this cycle's pop counts as room, so the 2-entry skid
    // buffer can sustain one entry per clock through the read latency.
    assign occupied   = count_q + {1'b0, inflight_q};
    assign slots_used = occupied - {1'b0, pop};
    assign has_room   = (slots_used < 2'd2);

    assign rdreq = (state_q == FETCH) & ~empty & has_room & ~flush;
    assign grant = rdreq & rdack;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (en) state_d = FETCH;
            end
            FETCH: begin
                if (!en) state_d = DRAIN;
            end
            DRAIN: begin
                if (en) begin
                    state_d = FETCH;
                end else if ((count_q == 2'd0) && !inflight_q) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                state_d = en ? FETCH : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = FLUSH;
    end

    always_comb begin
        raddr_d    = raddr_q;
        inflight_d = grant;
        count_d    = count_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        if (clearing) begin
            raddr_d    = waddr;
            inflight_d = 1'b0;
            count_d    = 2'd0;
            buf0_d     = '0;
            buf1_d     = '0;
        end else begin
            if (grant) raddr_d = raddr_q + 1'b1;
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        buf0_d  = rdata;
                        count_d = 2'd1;
                    end else if (count_q == 2'd1) begin
                        buf1_d  = rdata;
                        count_d = 2'd2;
                    end
                end
                2'b01: begin
                    buf0_d  = buf1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        buf0_d = rdata;
                    end else begin
                        buf0_d = buf1_q;
                        buf1_d = rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_q    <= IDLE;
            raddr_q    <= '0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            state_q    <= state_d;
            raddr_q    <= raddr_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

endmodule

// File: tb/tb_mon_fifo_rdctl.sv
// Self-checking bench for mon_fifo_rdctl: RAM model plus a scoreboard of expected
// entries keyed on the bench's own read-pointer model, and a table of level checks.
module tb_mon_fifo_rdctl;

    localparam int AW = 11;
    localparam int DW = 18;

    logic          clk;
    logic          rst_x;
    logic          en;
    logic          flush;
    logic [AW-1:0] waddr;
    logic          rdreq;
    logic          rdack;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] level;
    logic          empty;

    logic          ack_auto;
    logic          ack_val;
    logic          mon_on;
    logic [AW-1:0] exp_raddr;
    logic [DW-1:0] exp_q[$];
    int            grant_log[$];
    int            pop_log[$];
    int            grant_cnt;
    int            pop_cnt;
    int            cyc;
    int            n_vec;
    int            n_fail;

    typedef struct {
        logic [AW-1:0] waddr;
        logic [AW-1:0] exp_level;
        logic          exp_empty;
    } vec_t;

    vec_t vecs[5];

    mon_fifo_rdctl #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst_x    (rst_x),
        .en       (en),
        .flush    (flush),
        .waddr    (waddr),
        .rdreq    (rdreq),
        .rdack    (rdack),
        .raddr    (raddr),
        .rdata    (rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .level    (level),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rdack = ack_auto ? rdreq : ack_val;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[6:0], a} ^ 18'h2A5A5;
    endfunction

    // RAM model: data appears the cycle after a granted read, filler otherwise.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rdreq && rdack) rdata <= mem_word(raddr);
        else                rdata <= 18'h15555;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic en_i, input logic flush_i,
                                 input logic [AW-1:0] waddr_i, input logic ready_i);
        en        = en_i;
        flush     = flush_i;
        waddr     = waddr_i;
        out_ready = ready_i;
    endtask

    task automatic wait_grants(input int n, input int budget);
        int target;
        int k;
        target = grant_cnt + n;
        k = 0;
        while (grant_cnt < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (grant_cnt < target) checkOutput("grant_timeout", 32'(grant_cnt), 32'(target));
        #1;
    endtask

    task automatic wait_pops(input int n, input int budget);
        int target;
        int k;
        target = pop_cnt + n;
        k = 0;
        while (pop_cnt < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (pop_cnt < target) checkOutput("pop_timeout", 32'(pop_cnt), 32'(target));
        #1;
    endtask

    // Scoreboard: expected data is queued when a read is granted, checked on pop.
    always @(negedge clk) begin
        if (mon_on) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) checkOutput("unexpected_output", 32'(out_data), 32'h0);
                else                   checkOutput("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                pop_cnt++;
                pop_log.push_back(cyc);
            end
            if (flush) begin
                exp_q.delete();
                exp_raddr = waddr;
            end else if (rdreq && rdack) begin
                checkOutput("raddr_at_grant", 32'(raddr), 32'(exp_raddr));
                exp_q.push_back(mem_word(exp_raddr));
                exp_raddr = exp_raddr + 1'b1;
                grant_cnt++;
                grant_log.push_back(cyc);
            end
        end
    end

    initial begin
        int g0;
        int p0;
        n_vec = 0; n_fail = 0; grant_cnt = 0; pop_cnt = 0; cyc = 0;
        mon_on = 1'b0; ack_auto = 1'b1; ack_val = 1'b0; exp_raddr = '0;
        rst_x = 1'b0;
        applyStimulus(1'b0, 1'b0, 11'd0, 1'b0);

        vecs[0] = '{waddr: 11'd0,    exp_level: 11'd0,    exp_empty: 1'b1};
        vecs[1] = '{waddr: 11'd1,    exp_level: 11'd1,    exp_empty: 1'b0};
        vecs[2] = '{waddr: 11'd1024, exp_level: 11'd1024, exp_empty: 1'b0};
        vecs[3] = '{waddr: 11'd2047, exp_level: 11'd2047, exp_empty: 1'b0};
        vecs[4] = '{waddr: 11'd5,    exp_level: 11'd5,    exp_empty: 1'b0};

        #23 rst_x = 1'b1;
        @(negedge clk);
        checkOutput("reset_rdreq", 32'(rdreq), 32'h0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
        checkOutput("reset_empty", 32'(empty), 32'h1);
        checkOutput("reset_level", 32'(level), 32'h0);
        checkOutput("reset_raddr", 32'(raddr), 32'h0);
        checkOutput("reset_out_data", 32'(out_data), 32'h0);
        mon_on = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            applyStimulus(1'b0, 1'b0, vecs[i].waddr, 1'b0);
            @(negedge clk);
            checkOutput("table_level", 32'(level), 32'(vecs[i].exp_level));
            checkOutput("table_empty", 32'(empty), 32'(vecs[i].exp_empty));
            checkOutput("table_rdreq_idle", 32'(rdreq), 32'h0);
        end

        // Basic streaming of three entries with back-to-back output.
        @(posedge clk); #1;
        grant_log.delete(); pop_log.delete();
        applyStimulus(1'b1, 1'b0, 11'd3, 1'b1);
        wait_pops(3, 40);
        @(negedge clk);
        checkOutput("stream_raddr", 32'(raddr), 32'd3);
        checkOutput("stream_empty", 32'(empty), 32'h1);
        if (grant_log.size() >= 1 && pop_log.size() >= 3) begin
            checkOutput("first_latency", 32'(pop_log[0] - grant_log[0]), 32'd2);
            checkOutput("consecutive_1", 32'(pop_log[1] - pop_log[0]), 32'd1);
            checkOutput("consecutive_2", 32'(pop_log[2] - pop_log[0]), 32'd2);
        end else begin
            checkOutput("stream_log_size", 32'(pop_log.size()), 32'd3);
        end

        // Backpressure: two reads fill the credit, then no more requests.
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 11'd8, 1'b0);
        g0 = grant_cnt;
        p0 = pop_cnt;
        wait_grants(2, 20);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("bp_grants", 32'(grant_cnt - g0), 32'd2);
        checkOutput("bp_rdreq", 32'(rdreq), 32'h0);
        checkOutput("bp_out_valid", 32'(out_valid), 32'h1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_pops(5, 60);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("bp_pops", 32'(pop_cnt - p0), 32'd5);
        checkOutput("bp_queue_left", 32'(exp_q.size()), 32'd0);
        checkOutput("bp_empty", 32'(empty), 32'h1);

        // Retry: request held without acknowledge keeps the pointer still.
        @(posedge clk); #1;
        ack_auto = 1'b0; ack_val = 1'b0;
        applyStimulus(1'b1, 1'b0, 11'd10, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("retry_rdreq", 32'(rdreq), 32'h1);
            checkOutput("retry_raddr", 32'(raddr), 32'd8);
            @(posedge clk);
        end
        #1 ack_val = 1'b1;
        @(posedge clk); #1;
        ack_auto = 1'b1;
        @(negedge clk);
        checkOutput("retry_advance", 32'(raddr), 32'd9);
        p0 = pop_cnt;
        wait_pops(2, 30);

        // Wrap: flush to 2046, check full level, then read across the wrap.
        applyStimulus(1'b0, 1'b0, 11'd10, 1'b1);
        repeat (4) @(posedge clk); #1;
        applyStimulus(1'b0, 1'b1, 11'd2046, 1'b1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 11'd2046, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("wrap_raddr_start", 32'(raddr), 32'd2046);
        checkOutput("wrap_level_zero", 32'(level), 32'd0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 11'd2045, 1'b1);
        @(negedge clk);
        checkOutput("full_level", 32'(level), 32'd2047);
        checkOutput("full_empty", 32'(empty), 32'h0);
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 11'd1, 1'b1);
        wait_pops(3, 40);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("wrap_raddr_end", 32'(raddr), 32'd1);
        checkOutput("wrap_level_end", 32'(level), 32'd0);
        checkOutput("wrap_empty", 32'(empty), 32'h1);

        // Flush with one buffered entry and one read in flight.
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 11'd9, 1'b0);
        p0 = pop_cnt;
        wait_grants(2, 20);
        applyStimulus(1'b1, 1'b1, 11'd9, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 11'd9, 1'b0);
        @(negedge clk);
        checkOutput("flush_out_valid", 32'(out_valid), 32'h0);
        checkOutput("flush_raddr", 32'(raddr), 32'd9);
        checkOutput("flush_rdreq", 32'(rdreq), 32'h0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checkOutput("flush_no_output", 32'(pop_cnt - p0), 32'd0);
        checkOutput("flush_idle_valid", 32'(out_valid), 32'h0);
        checkOutput("flush_idle_empty", 32'(empty), 32'h1);

        // Asynchronous reset in the middle of a transfer.
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 11'd13, 1'b0);
        wait_grants(1, 20);
        mon_on = 1'b0;
        #2 rst_x = 1'b0;
        #1;
        checkOutput("areset_raddr", 32'(raddr), 32'd0);
        checkOutput("areset_out_valid", 32'(out_valid), 32'h0);
        checkOutput("areset_rdreq", 32'(rdreq), 32'h0);
        #1 rst_x = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
